// File: rtl/stall_ctrl.sv
// Pipeline hazard controller: load-use and branch bubbles, memory-wait stalls with
// a timeout that parks the pipeline in a sticky error state, and a saturating stall counter.
module stall_ctrl #(
    parameter int REGW    = 4,
    parameter int TIMEOUT = 16,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [REGW-1:0] rs1_d,
    input  logic [REGW-1:0] rs2_d,
    input  logic [REGW-1:0] rd_e,
    input  logic            memtoreg_e,
    input  logic            branch_e,
    input  logic            mem_req_m,
    input  logic            mem_ready,
    output logic            stall_f,
    output logic            stall_d,
    output logic            stall_e,
    output logic            stall_m,
    output logic            flush_d,
    output logic            flush_e,
    output logic            mem_err,
    output logic [CNTW-1:0] stall_cycles,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERR     = 2'd2
    } state_t;

    localparam logic [7:0]      WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [CNTW-1:0] CNT_MAX   = '1;

    state_t          state_q, state_d;
    logic [7:0]      wait_cnt_q, wait_cnt_d;
    logic            mem_err_q, mem_err_d;
    logic [CNTW-1:0] stall_cycles_q, stall_cycles_d;

    logic mem_pend, ldu, ldu_stall;

    assign mem_pend  = mem_req_m & ~mem_ready;
    assign ldu       = memtoreg_e & ((rd_e == rs1_d) | (rd_e == rs2_d));
    // A taken branch squashes the dependent instruction, so it wins over load-use.
    assign ldu_stall = ldu & ~branch_e;

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        mem_err_d      = mem_err_q;
        stall_f        = 1'b0;
        stall_d        = 1'b0;
        stall_e        = 1'b0;
        stall_m        = 1'b0;
        flush_d        = 1'b0;
        flush_e        = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_pend) begin
                    {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                    state_d    = MEMWAIT;
                    wait_cnt_d = 8'd1;
                end else begin
                    stall_f = ldu_stall;
                    stall_d = ldu_stall;
                    flush_d = branch_e;
                    flush_e = branch_e | ldu;
                end
            end
            MEMWAIT: begin
                if (mem_ready) begin
                    stall_f    = ldu_stall;
                    stall_d    = ldu_stall;
                    flush_d    = branch_e;
                    flush_e    = branch_e | ldu;
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else begin
                    {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d   = ERR;
                        mem_err_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            ERR: begin
                {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (reset) begin
            {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e} = 6'b0;
        end

        stall_cycles_d = stall_cycles_q;
        if (stall_f && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            wait_cnt_q     <= 8'd0;
            mem_err_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_err_q      <= mem_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_cycles_q;
    assign state_dbg    = state_q;

endmodule
